// File: rtl/inst_rom_arbiter_if.sv
// Bundle of the two requester ports (IF fetch, LS code-space read) and the
// combinational instruction-ROM port that the arbiter shares between them.
interface inst_rom_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // IF fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_stall;
  logic [DATA_W-1:0] if_inst;
  logic              if_valid;

  // load/store read port
  logic              ls_req;
  logic [ADDR_W-1:0] ls_addr;
  logic              ls_stall;
  logic [DATA_W-1:0] ls_data;
  logic              ls_valid;
  logic              ls_err;

  // ROM port
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_inst;

  // Environment side: requesters plus the ROM model.
  modport master (
    output if_req, if_addr, if_flush,
    input  if_stall, if_inst, if_valid,
    output ls_req, ls_addr,
    input  ls_stall, ls_data, ls_valid, ls_err,
    input  rom_ce, rom_addr,
    output rom_inst
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, if_flush,
    output if_stall, if_inst, if_valid,
    input  ls_req, ls_addr,
    output ls_stall, ls_data, ls_valid, ls_err,
    output rom_ce, rom_addr,
    input  rom_inst
  );
endinterface

// File: rtl/inst_rom_arbiter.sv
// Round-robin arbiter sharing one combinational instruction ROM between the
// IF stage and the load/store path; responses are registered, 1-cycle latency.
module inst_rom_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_rom_arbiter_if.slave    bus
);

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

  port_e             last;
  logic              ls_aligned;
  logic              ls_eligible;
  logic              if_grant;
  logic              ls_grant;
  logic              any_grant;
  logic [ADDR_W-1:0] grant_addr;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ls_aligned  = (bus.ls_addr[1:0] == 2'b00);
    ls_eligible = bus.ls_req && ls_aligned;
    // On contention the port that was not served last wins.
    if_grant    = bus.if_req && (!ls_eligible || (last == PORT_LS));
    ls_grant    = ls_eligible && (!bus.if_req || (last == PORT_IF));
    any_grant   = if_grant || ls_grant;
    grant_addr  = '0;
    if (if_grant) begin
      grant_addr = bus.if_addr;
    end else if (ls_grant) begin
      grant_addr = bus.ls_addr;
    end
  end

  // The ROM is kept quiet for the whole reset window; stalls stay live.
  assign bus.rom_ce   = any_grant && rst;
  assign bus.rom_addr = rst ? grant_addr : '0;
  assign bus.if_stall = bus.if_req && !if_grant;
  assign bus.ls_stall = bus.ls_req && !ls_grant;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last         <= PORT_LS;
      bus.if_inst  <= '0;
      bus.if_valid <= 1'b0;
      bus.ls_data  <= '0;
      bus.ls_valid <= 1'b0;
      bus.ls_err   <= 1'b0;
    end else begin
      if (if_grant) begin
        last <= PORT_IF;
      end else if (ls_grant) begin
        last <= PORT_LS;
      end

      // A flushed fetch still consumed its grant; only the response dies.
      bus.if_valid <= if_grant && !bus.if_flush;
      if (if_grant && !bus.if_flush) begin
        bus.if_inst <= bus.rom_inst;
      end

      bus.ls_valid <= ls_grant;
      if (ls_grant) begin
        bus.ls_data <= bus.rom_inst;
      end

      bus.ls_err <= bus.ls_req && !ls_aligned;
    end
  end

endmodule

// File: doc/inst_rom_arbiter.md
# inst_rom_arbiter

Shares the single combinational instruction ROM between two requesters: the IF stage (instruction fetch) and the load/store path (constant and literal reads from code space). The block grants at most one requester per cycle using round-robin arbitration. It drives the ROM's `ce`/`addr` and registers the returned word toward the granted requester. It sits between `pc_reg`/`mem` and `inst_rom`, with the ROM a pure combinational slave.

## Interface
- `ADDR_W`, default 32: address width; matches `InstAddr_t`.
- `DATA_W`, default 32: word width; matches `Inst_t`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `if_req` in 1: IF requests a fetch this cycle.
- `if_addr` in ADDR_W: fetch byte address.
- `if_flush` in 1: kills the IF response being captured this cycle.
- `if_stall` out 1: IF requested but was not granted this cycle (combinational).
- `if_inst` out DATA_W: registered fetched word.
- `if_valid` out 1: `if_inst` is new this cycle.
- `ls_req` in 1: load/store path requests a read.
- `ls_addr` in ADDR_W: read byte address.
- `ls_stall` out 1: LS requested but was not granted, or is being rejected (combinational).
- `ls_data` out DATA_W: registered read word.
- `ls_valid` out 1: `ls_data` is new this cycle.
- `ls_err` out 1: the previous LS request was misaligned (one-cycle pulse).
- `rom_ce` out 1: ROM chip enable (`ChipEnable` when a grant is issued).
- `rom_addr` out ADDR_W: ROM byte address.
- `rom_inst` in DATA_W: combinational ROM data.

## Operation
- **Eligibility.**
  - `if_req` is always eligible. The IF side is never checked for alignment; the ROM ignores `addr[1:0]`.
  - `ls_req` is eligible only when `ls_addr[1:0]==0`.
  - A misaligned `ls_req` is never granted and never reaches the ROM. It raises `ls_stall` in that cycle and sets `ls_err`=1 in the next cycle. `ls_valid` stays 0.
- **Arbitration** uses a 1-bit `last` register (0=IF, 1=LS).
  - Only one eligible requester: grant it.
  - Both eligible: grant the port that is not `last`.
  - `last` updates to the granted port on every grant and holds when there is no grant.
  - Reset value of `last` is LS, so IF wins the first contention.
- **ROM drive** (combinational):
  - `rom_ce`=1 iff a grant is issued.
  - `rom_addr` is the granted port's address, otherwise 0.
  - With `rom_ce`=0, `rom_inst` is `ZeroWord` and is ignored.
- **Stall outputs:**
  - `if_stall` = `if_req` & ~`if_grant`.
  - `ls_stall` = `ls_req` & ~`ls_grant`.
  - A stalled requester must hold its request and address stable until granted.
- **Response capture** on the rising edge:
  - IF granted and `if_flush`=0: `if_inst`<=`rom_inst`, `if_valid`<=1.
  - IF granted and `if_flush`=1: `if_valid`<=0 and `if_inst` holds its value. `last` still updates, because the grant was consumed.
  - LS granted: `ls_data`<=`rom_inst`, `ls_valid`<=1.
  - Otherwise: the port's valid goes 0 and its data register holds.
  - `if_flush` has no effect on the LS side.

## Timing
- Response latency is exactly 1 cycle: a grant in cycle t gives valid in cycle t+1.
- Throughput is one grant per cycle across both ports.
- Under continuous contention, grants alternate IF, LS, IF, LS… Worst-case wait is 1 cycle per port, so there is no starvation.
- An IF-only request stream gets a grant every cycle, with `if_valid` high every cycle from t+1.
- **Reset values (while `rst`=0, asynchronously):** `if_inst`=0, `ls_data`=0, `if_valid`=0, `ls_valid`=0, `ls_err`=0, `last`=LS.
- **Stall and ROM outputs during reset:** `if_stall`/`ls_stall` still follow their combinational equations. `rom_ce`/`rom_addr` are forced to 0 while in reset.
- **Reset asserted mid-operation:** the pending response is discarded; no valid pulse follows reset deassertion.
- **First edge after reset release:** the first rising edge after `rst` goes high samples normally.
- **Simultaneous events:**
  - Misaligned LS together with an IF request: IF is granted, and `last` is unaffected by the rejected LS.
  - Both requesting while `if_flush`=1: arbitration is unchanged, and only `if_valid` is suppressed.

## Test plan
- **Reset.** Hold `rst`=0 while toggling inputs → all registered outputs are 0 and `rom_ce`=0. Release, then `if_req`=1 with `if_addr`=0x0 → `rom_ce`=1 and `rom_addr`=0x0 the same cycle; `if_valid`=1 and `if_inst`=mem[0] the next cycle.
- **Contention.** Both requesting for 4 cycles with `if_addr`=0x10 and `ls_addr`=0x20 → grants go IF, LS, IF, LS. `if_stall`/`ls_stall` toggle opposite each other, and `if_inst`=mem[4], `ls_data`=mem[8] on alternating cycles.
- **Misaligned LS.** `ls_addr`=0x22 with `if_req`=0 → `rom_ce`=0 and `ls_stall`=1; the next cycle `ls_err`=1 and `ls_valid`=0.
- **Flush.** IF granted at 0x8 with `if_flush`=1 → the next cycle `if_valid`=0 and `if_inst` is unchanged. The next contention grants LS.
- **Reset mid-operation.** Assert `rst` asynchronously between an LS grant and its capture edge → `ls_valid` never pulses and `ls_data`=0.
- **Single port.** LS alone for 3 cycles at 0x0, 0x4, 0x8 → `ls_valid` is high for 3 consecutive cycles carrying mem[0..2], with `ls_stall`=0 throughout.
